// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port: A has fixed priority,
// B is forced through after STARVE_LIMIT consecutive losses. The winner is registered.
module regfile_write_arbiter #(
    parameter int size         = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int ZERO_REG     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [size-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [size-1:0] b_data,
    output logic            b_ready,
    input  logic            wb_stall,
    output logic            reg_write,
    output logic [4:0]      write_register,
    output logic [size-1:0] write_data,
    output logic [3:0]      starve_cnt
);

    localparam logic [3:0] LIMIT         = 4'(STARVE_LIMIT);
    localparam bit         SUPPRESS_ZERO = (ZERO_REG != 0);

    logic            reg_write_q, reg_write_d;
    logic [4:0]      write_register_q, write_register_d;
    logic [size-1:0] write_data_q, write_data_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            force_b;

    // Grant: nothing is accepted during reset or a downstream stall
    always_comb begin
        force_b = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !wb_stall) begin
            force_b = (starve_cnt_q == LIMIT) && b_valid;
            b_ready = b_valid && (force_b || !a_valid);
            a_ready = a_valid && !force_b;
        end
    end

    always_comb begin
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        starve_cnt_d     = starve_cnt_q;
        if (a_ready) begin
            write_register_d = a_addr;
            write_data_d     = a_data;
            reg_write_d      = !(SUPPRESS_ZERO && (a_addr == 5'd0));
        end else if (b_ready) begin
            write_register_d = b_addr;
            write_data_d     = b_data;
            reg_write_d      = !(SUPPRESS_ZERO && (b_addr == 5'd0));
        end
        // Loss counter saturates at the limit so the forced grant stays armed
        if (!wb_stall) begin
            if (b_ready || !b_valid) begin
                starve_cnt_d = 4'd0;
            end else if (a_ready && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q      <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= '0;
            starve_cnt_q     <= 4'd0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            starve_cnt_q     <= starve_cnt_d;
        end
    end

    assign reg_write      = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign starve_cnt     = starve_cnt_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU result, default priority) and B (load/memory result).
- Fixed priority to A, with a starvation counter that forces a grant to B after STARVE_LIMIT consecutive losses.
- The winning write is registered and drives the register file write port one cycle after acceptance.
- Writes to register 0 can optionally be suppressed.

Parameters:
- size, 32, data width of write data.
- STARVE_LIMIT, 3, consecutive B losses after which B wins (range 1..15).
- ZERO_REG, 1, when 1, writes addressed to register 0 are accepted but not issued.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  5  requester A destination register.
- a_data  input  size  requester A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_addr  input  5  requester B destination register.
- b_data  input  size  requester B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- wb_stall  input  1  downstream freeze; no acceptance while high.
- reg_write  output  1  register file write enable (registered).
- write_register  output  5  register file write address (registered).
- write_data  output  size  register file write data (registered).
- starve_cnt  output  4  current B loss count (debug/verification).

Behaviour:
- Handshake: a transfer occurs on a rising clk edge when X_valid and X_ready are both 1. Requesters hold valid, addr and data stable until ready.
- Grant logic (combinational) when wb_stall=0:
  - force_b = (starve_cnt == STARVE_LIMIT) and b_valid.
  - b_ready = b_valid and (force_b or not a_valid).
  - a_ready = a_valid and not force_b.
  - At most one of a_ready and b_ready is 1.
- wb_stall=1: a_ready=0 and b_ready=0. reg_write=0 on the next cycle. starve_cnt holds.
- Output register: on the edge of an accepted transfer, latch the winner's addr and data into write_register and write_data. reg_write=1 for exactly one cycle, unless ZERO_REG=1 and addr=0, in which case reg_write=0.
- Latency: one cycle from acceptance to reg_write. Throughput: one write per cycle.
- No accept in a cycle: reg_write=0 on the next cycle. write_register and write_data hold their previous values.
- starve_cnt update (when wb_stall=0):
  - b_valid and a_ready: starve_cnt+1, saturating at STARVE_LIMIT.
  - b_ready: clear to 0.
  - b_valid=0: clear to 0.
- After a forced B grant, starve_cnt=0 and A regains priority the next cycle.
- Zero-register writes take part in arbitration and update starve_cnt normally. Only the reg_write pulse is suppressed.
- Reset (rst=1 at an edge):
  - reg_write=0, write_register=0, write_data=0, starve_cnt=0.
  - a_ready and b_ready are forced to 0 while rst=1.
  - An in-flight transfer accepted on the reset edge is discarded.
- No internal buffering. A requester that is not granted keeps valid asserted; no request is ever lost or duplicated.

Test Plan:
- Reset, then A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle reg_write=1, write_register=5, write_data=0xDEADBEEF; the cycle after, reg_write=0.
- Contention with STARVE_LIMIT=3: A and B valid continuously (B addr=7, data=0x11) -> A granted for 3 cycles with starve_cnt 1,2,3; 4th cycle b_ready=1; next cycle write_register=7, write_data=0x11, starve_cnt=0; A resumes.
- Zero register: B only, b_addr=0, b_data=0xFF -> b_ready=1; next cycle reg_write=0, write_register=0; starve_cnt=0.
- Stall: both valid, starve_cnt=2, wb_stall=1 for 4 cycles -> no readys, reg_write=0, starve_cnt stays 2; after release, A granted and starve_cnt=3, then B granted.
- Reset mid-contention: starve_cnt=2, rst=1 for 1 cycle -> next cycle starve_cnt=0, reg_write=0; after rst drops, A wins first.
- Back-to-back: A valid with addrs 1,2,3 on consecutive cycles, B idle -> reg_write=1 for three consecutive cycles with write_register 1,2,3 in order.
